// File: rtl/arb_pkg.sv
// Shared types and default parameters for the round-robin arbiter.
package arb_pkg;

   typedef enum logic {IDLE, OWNED} arb_state_t;

   localparam int ARB_N_DEF        = 2;
   localparam int ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int N     = 2,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [PTR_W-1:0] idx
);

   // NOTE: every output gets a default first so no path through the loop infers a latch.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // Scan from the far end back toward ptr so the closest hit is the last write.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % N]) begin
            valid = 1'b1;
            idx   = PTR_W'((int'(ptr) + i) % N);
         end
      end
   end

endmodule

// File: rtl/rr_arb.sv
// Registered round-robin arbiter with a per-tenure hold limit.
module rr_arb
   import arb_pkg::*;
#(
   parameter int N        = ARB_N_DEF,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         request,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy
);

   localparam int PTR_W = $clog2(N);
   localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(N - 1);
   // With no limit the counter simply parks at its maximum value.
   localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

   arb_state_t       state;
   logic [PTR_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;

   logic             pick_valid;
   logic [PTR_W-1:0] pick_idx;
   logic [N-1:0]     pick_onehot;
   logic [PTR_W-1:0] pick_next;
   logic             limit_hit;
   logic             release_now;

   rr_pick #(.N(N), .PTR_W(PTR_W)) u_pick (
      .req   (request),
      .ptr   (ptr),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      pick_onehot           = '0;
      pick_onehot[pick_idx] = 1'b1;
      pick_next             = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
      limit_hit             = (MAX_HOLD != 0) && (hold_cnt >= CNT_SAT);
      release_now           = !request[gnt_id] || limit_hit;
   end

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         grant    <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= OWNED;
                  grant    <= pick_onehot;
                  gnt_id   <= pick_idx;
                  busy     <= 1'b1;
                  hold_cnt <= CNT_W'(1);
                  ptr      <= pick_next;
               end
            end
            OWNED: begin
               // ptr already sits past the owner, so the owner only wins again if alone.
               if (release_now) begin
                  if (pick_valid) begin
                     grant    <= pick_onehot;
                     gnt_id   <= pick_idx;
                     hold_cnt <= CNT_W'(1);
                     ptr      <= pick_next;
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                     busy  <= 1'b0;
                  end
               end else if (hold_cnt != CNT_SAT) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb.sv
// Directed bench for rr_arb with N=2, MAX_HOLD=4; inputs change and outputs are sampled on negedge.
module tb_rr_arb;

   logic       clk;
   logic       rst_n;
   logic [1:0] request;
   logic [1:0] grant;
   logic [0:0] gnt_id;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   rr_arb #(.N(2), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .request (request),
      .grant   (grant),
      .gnt_id  (gnt_id),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic [1:0] g, input logic id, input logic b);
      check({tag, ".grant"},  8'(grant),  8'(g));
      check({tag, ".gnt_id"}, 8'(gnt_id), 8'(id));
      check({tag, ".busy"},   8'(busy),   8'(b));
   endtask

   // One clock edge, then land on the following negedge for sampling/driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n   = 1'b0;
      request = 2'b11;
      @(negedge clk);
      expect_out("reset0", 2'b00, 1'b0, 1'b0);
      step();
      expect_out("reset1", 2'b00, 1'b0, 1'b0);
      step();
      expect_out("reset2", 2'b00, 1'b0, 1'b0);

      // Single requester
      rst_n   = 1'b1;
      request = 2'b01;
      step();
      expect_out("single_gnt", 2'b01, 1'b0, 1'b1);
      step();
      expect_out("single_hold", 2'b01, 1'b0, 1'b1);
      request = 2'b00;
      step();
      expect_out("single_drop", 2'b00, 1'b0, 1'b0);

      // Contention from idle with ptr back at 0
      rst_n = 1'b0;
      #1;
      rst_n   = 1'b1;
      request = 2'b11;
      step();
      expect_out("cont_first", 2'b01, 1'b0, 1'b1);
      request = 2'b10;
      step();
      expect_out("cont_handover", 2'b10, 1'b1, 1'b1);
      request = 2'b00;
      step();
      expect_out("cont_idle", 2'b00, 1'b1, 1'b0);

      // Hold limit: ptr is 0 here, constant contention
      request = 2'b11;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("hold_lim[%0d]", i), 8'(grant), ((i / 4) % 2 == 1) ? 8'h02 : 8'h01);
      end
      request = 2'b00;
      step();
      expect_out("hold_idle", 2'b00, 1'b0, 1'b0);

      // Lone owner past the limit: ptr is 1 here
      request = 2'b10;
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("lone_gnt[%0d]", i), 8'(grant), 8'h02);
         check($sformatf("lone_cnt[%0d]", i), 8'(dut.hold_cnt), 8'((i % 4) + 1));
      end

      // Reset mid-grant, asynchronously between edges
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      rst_n   = 1'b1;
      request = 2'b11;
      step();
      expect_out("post_rst", 2'b01, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
